decode_stage: RTL
=================

Name: decode_stage

Overview:
- Decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Consumes InstrD/PCD/PCPlus4D. Holds the 32x32 register file (written back from W stage), decodes control, and sign-extends immediates.
- Drives the ID/EX pipeline register feeding the execute stage. Exposes Rs1D/Rs2D combinationally to the hazard unit.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural registers (address width = log2(NREGS) = 5)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- InstrD  in  32  instruction from fetch; 0 = bubble
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PC+4 of InstrD
- FlushE  in  1  convert next ID/EX contents into a bubble
- RegWriteW  in  1  write-back enable
- RdW  in  5  write-back destination
- ResultW  in  32  write-back data
- Rs1D, Rs2D  out  5  InstrD[19:15], InstrD[24:20]; combinational
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered data
- Rs1E, Rs2E, RdE  out  5 each  registered register addresses
- IllegalE  out  1  registered illegal-instruction flag

Behaviour:
- Latency: 1 cycle from InstrD to the *E outputs. No stall input; the stage captures every cycle.
- Capture priority: reset > FlushE > normal capture.
- reset: every *E output and IllegalE = 0. All register-file entries = 0.
- FlushE=1 at an edge: every *E output = 0 (NOP bubble). Register-file write still occurs.
- Register file:
  - Written on the rising edge when RegWriteW=1 and RdW!=0.
  - x0 is never written and always reads 0.
  - Reads are combinational.
- Supported instructions and decoded control:
  - lw (0000011): RegWrite=1, ALUSrc=1, ResultSrc=01, ImmSrc=I, ALUControl=add.
  - sw (0100011): MemWrite=1, ALUSrc=1, ImmSrc=S, ALUControl=add.
  - R-type (0110011): RegWrite=1. funct3/funct7[5] select ALUControl: add 000/0, sub 000/1, slt 010, or 110, and 111.
  - I-ALU (0010011): addi, slti, ori, andi. RegWrite=1, ALUSrc=1. funct7[5] is ignored.
  - beq (1100011): Branch=1, ALUControl=sub, ImmSrc=B.
  - jal (1101111): RegWrite=1, Jump=1, ResultSrc=10, ImmSrc=J.
- Immediate sign extension (always sign-extend from Instr[31]):
  - I = Instr[31:20].
  - S = {Instr[31:25], Instr[11:7]}.
  - B = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - J = {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
- Illegal instructions: unsupported opcode, or unsupported funct3/funct7 within a supported opcode.
  - All control is forced to 0 and IllegalE=1.
  - InstrD==0 is a bubble: control 0, IllegalE=0.
- RdE = InstrD[11:7] for every instruction; the hazard unit qualifies it with RegWriteE.

Optional Feature:
- Macro RISCV_REGFILE_BYPASS_EN.
- Defined: on a read, if RegWriteW=1, RdW!=0 and RdW equals the read address, RD1/RD2 return ResultW in the same cycle (write-through). The W->D hazard needs no stall.
- Undefined: reads return only stored contents. A same-cycle write is visible from the next cycle; the hazard unit must stall decode one cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants;
  - ALUControl, ResultSrc and ImmSrc encodings (ImmSrc: 00 I, 01 S, 10 B, 11 J);
  - XLEN.
- One sub-module, register_file: 2 read ports, 1 write port, x0 handling, bypass under the macro.
- Control decoder and immediate extender are combinational blocks inside decode_stage.

Test Plan:
- Reset: reset=1 mid-run with live InstrD -> all *E outputs 0 immediately (asynchronous). After release, x5 reads 0.
- Write then read: write x5=0xDEADBEEF (RegWriteW=1, RdW=5). Next cycle InstrD=add x7,x5,x0 (0x000283B3) -> RD1E=0xDEADBEEF, RegWriteE=1, ALUControlE=000, RdE=7.
- x0 protection: write RdW=0, ResultW=0x1234 -> subsequent read of x0 gives RD1E=0.
- Immediates:
  - sw x6,-4(x2) (0xFE612E23) -> ImmExtE=0xFFFFFFFC, MemWriteE=1.
  - beq with offset -8 -> ImmExtE=0xFFFFFFF8, BranchE=1.
- FlushE and illegal:
  - FlushE=1 with lw in InstrD -> next cycle all *E outputs 0.
  - InstrD=0xFFFFFFFF -> IllegalE=1, all control 0.
  - InstrD=0 -> IllegalE=0.
- Same-cycle write/read of x9: RD1E=new value with RISCV_REGFILE_BYPASS_EN, old value without.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I decode constants, encodings and control bundle
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  // Opcodes of the supported instruction subset
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  // Control fields carried into the execute stage
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_t result_src;
    alu_ctrl_t   alu_control;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 2R1W register file, x0 hardwired; write-through under RISCV_REGFILE_BYPASS_EN
module register_file #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   addr1,
  input  logic [AW-1:0]   addr2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);
  import riscv_pkg::*;

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  // Storage: cleared on reset, x0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Combinational read ports; x0 always reads zero
  always_comb begin
    rd1 = (addr1 == '0) ? '0 : regs[addr1];
    rd2 = (addr2 == '0) ? '0 : regs[addr2];
`ifdef RISCV_REGFILE_BYPASS_EN
    // Same-cycle write-back is forwarded so decode never has to wait on W
    if (wr_en && (waddr == addr1)) rd1 = wdata;
    if (wr_en && (waddr == addr2)) rd2 = wdata;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with ID/EX register (optional RISCV_REGFILE_BYPASS_EN)
module decode_stage #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            IllegalE
);
  import riscv_pkg::*;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] imm_ext;
  imm_src_t        imm_src;
  ctrl_t           ctrl;
  logic            legal;
  logic            illegal;
  alu_ctrl_t       alu_f3;
  logic            f3_ok;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_register_file (
    .clk   (clk),
    .reset (reset),
    .addr1 (Rs1D),
    .addr2 (Rs2D),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (RegWriteW),
    .waddr (RdW),
    .wdata (ResultW)
  );

  // ALU operation shared by R-type and I-ALU, selected by funct3
  always_comb begin
    alu_f3 = ALU_ADD;
    f3_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_f3 = ALU_ADD;
      3'b010:  alu_f3 = ALU_SLT;
      3'b110:  alu_f3 = ALU_OR;
      3'b111:  alu_f3 = ALU_AND;
      default: f3_ok  = 1'b0;
    endcase
  end

  // Control decoder; anything not explicitly legal leaves control at zero
  always_comb begin
    ctrl  = '0;
    legal = 1'b0;
    case (opcode)
      OP_LOAD: if (funct3 == 3'b010) begin
        legal           = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        legal          = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_RTYPE: begin
        if (funct7 == 7'b0000000 && f3_ok) begin
          legal            = 1'b1;
          ctrl.reg_write   = 1'b1;
          ctrl.alu_control = alu_f3;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal            = 1'b1;
          ctrl.reg_write   = 1'b1;
          ctrl.alu_control = ALU_SUB;
        end
      end
      OP_IALU: if (f3_ok) begin
        legal            = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = alu_f3;
      end
      OP_BRANCH: if (funct3 == 3'b000) begin
        legal            = 1'b1;
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        legal           = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      default: ;
    endcase
    // An all-zero word is a pipeline bubble, not a fault
    illegal = !legal && (InstrD != 32'd0);
  end

  // Immediate format follows the opcode alone; it is data, not gated by legality
  always_comb begin
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

  // Sign-extending immediate generator
  always_comb begin
    case (imm_src)
      IMM_S:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J:   imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  // ID/EX register: reset and flush both load a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      IllegalE    <= 1'b0;
    end else begin
      RegWriteE   <= ctrl.reg_write;
      MemWriteE   <= ctrl.mem_write;
      JumpE       <= ctrl.jump;
      BranchE     <= ctrl.branch;
      ALUSrcE     <= ctrl.alu_src;
      ResultSrcE  <= ctrl.result_src;
      ALUControlE <= ctrl.alu_control;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= InstrD[11:7];
      IllegalE    <= illegal;
    end
  end

endmodule
